// File: rtl/control_seq.sv
// control_seq: cycle sequencer for the Nandy core.
//
// Generates the decoder phase (`cycle`), stretches memory phases with the
// `mem_rdy` handshake, retires instructions (`fetch`), optionally takes
// interrupts between instructions, and halts with a sticky `bus_err` when a
// memory access stalls for longer than TIMEOUT clocks.
//
// Optional feature macro: SEQ_IRQ_EN
//   defined   : IRQ state, `ie` register and `irq_ack` pulse are present.
//   undefined : `irq`, `nCLI`, `nLJR` are ignored; `ie` and `irq_ack` tie to 0.
//
// Parameters:
//   INST_W  - instruction width; class bits are inst[INST_W-1:INST_W-3]
//   WAIT_W  - wait-state counter width
//   TIMEOUT - stalled clocks tolerated before bus error (0 disables)
//
// Ports:
//   clk      in   clock, all state on rising edge
//   nRST     in   synchronous active-low reset
//   inst     in   instruction held in the fetch register
//   mem_rdy  in   memory port completes the current access this cycle
//   irq      in   level interrupt request
//   nCLI     in   decoder: low at retire clears interrupt enable
//   nLJR     in   decoder: low at retire sets interrupt enable
//   cycle    out  decoder phase, 0 = first, 1 = second
//   mem_req  out  memory access pending this cycle
//   fetch    out  instruction retires this cycle
//   stall    out  memory access pending and not ready
//   irq_ack  out  one-clock pulse on interrupt entry
//   ie       out  interrupt enable state
//   bus_err  out  sticky timeout flag

module control_seq #(
  parameter int unsigned INST_W  = 8,
  parameter int unsigned WAIT_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [INST_W-1:0] inst,
  input  logic              mem_rdy,
  input  logic              irq,
  input  logic              nCLI,
  input  logic              nLJR,
  output logic              cycle,
  output logic              mem_req,
  output logic              fetch,
  output logic              stall,
  output logic              irq_ack,
  output logic              ie,
  output logic              bus_err
);

`ifdef SEQ_IRQ_EN
  typedef enum logic [1:0] {StEx0, StEx1, StIrq, StErr} state_e;
`else
  typedef enum logic [1:0] {StEx0, StEx1, StErr} state_e;
`endif

  state_e            stateQ, stateD;
  logic [WAIT_W-1:0] waitCntQ, waitCntD;

  logic twoPhase;
  logic memClass;
  logic memReqC;
  logic stallC;
  logic retire;
  logic timedOut;

  // Only the top two class bits steer the sequencer; the rest belong to the decoder.
  assign twoPhase = inst[INST_W-1];
  assign memClass = twoPhase & ~inst[INST_W-2];

  logic unusedInstBits;
  assign unusedInstBits = ^inst[INST_W-3:0];

`ifdef SEQ_IRQ_EN
  logic ieQ, ieD;
  logic ieNext;

  // Clear wins when the decoder asserts both controls on the same retire.
  always_comb begin
    ieNext = ieQ;
    if (!nCLI) begin
      ieNext = 1'b0;
    end else if (!nLJR) begin
      ieNext = 1'b1;
    end
  end
`else
  logic unusedIrqIn;
  assign unusedIrqIn = ^{irq, nCLI, nLJR};
`endif

  always_comb begin
    stateD  = stateQ;
    memReqC = 1'b0;
    retire  = 1'b0;
`ifdef SEQ_IRQ_EN
    ieD     = ieQ;
`endif

    case (stateQ)
      StEx0: begin
        if (twoPhase) begin
          memReqC = 1'b1;
          if (mem_rdy) begin
            stateD = StEx1;
          end
        end else begin
          retire = 1'b1;
        end
      end
      StEx1: begin
        if (memClass) begin
          memReqC = 1'b1;
          retire  = mem_rdy;
        end else begin
          // Jump class: second phase needs no memory access.
          retire = 1'b1;
        end
      end
`ifdef SEQ_IRQ_EN
      StIrq: begin
        ieD    = 1'b0;
        stateD = StEx0;
      end
`endif
      StErr: begin
        stateD = StErr;
      end
      default: begin
        stateD = StEx0;
      end
    endcase

    stallC = memReqC & ~mem_rdy;

    if (retire) begin
`ifdef SEQ_IRQ_EN
      ieD    = ieNext;
      // irq is sampled only here; it is never latched between retires.
      stateD = (irq && ieNext) ? StIrq : StEx0;
`else
      stateD = StEx0;
`endif
    end

    timedOut = (TIMEOUT != 0) && stallC && (waitCntQ == WAIT_W'(TIMEOUT));
    if (timedOut) begin
      stateD = StErr;
    end

    if ((stateD != stateQ) || mem_rdy) begin
      waitCntD = '0;
    end else if (stallC) begin
      waitCntD = waitCntQ + 1'b1;
    end else begin
      waitCntD = waitCntQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      stateQ   <= StEx0;
      waitCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
    end
  end

`ifdef SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (!nRST) begin
      ieQ <= 1'b0;
    end else begin
      ieQ <= ieD;
    end
  end

  assign ie      = ieQ;
  assign irq_ack = nRST & (stateQ == StIrq);
`else
  assign ie      = 1'b0;
  assign irq_ack = 1'b0;
`endif

  // Pulses and phase are masked while reset is held so nothing leaks out
  // before the reset edge lands.
  assign fetch   = nRST & retire;
  assign mem_req = nRST & memReqC;
  assign stall   = nRST & stallC;
  assign cycle   = nRST & (stateQ == StEx1);
  assign bus_err = (stateQ == StErr);

endmodule

// File: tb/tb_control_seq.sv
// Testbench for control_seq: a table of per-clock input/expected-output
// records is driven one per clock; each record is queued when driven and
// popped and compared on the following falling edge. Expectations for the
// interrupt outputs follow whether SEQ_IRQ_EN is defined for this build.

module tb_control_seq;

`ifdef SEQ_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic       clk;
  logic       nRST;
  logic [7:0] inst;
  logic       mem_rdy;
  logic       irq;
  logic       nCLI;
  logic       nLJR;
  logic       cycle;
  logic       mem_req;
  logic       fetch;
  logic       stall;
  logic       irq_ack;
  logic       ie;
  logic       bus_err;

  int errors;
  int checks;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] inst;
    logic       rdy;
    logic       irq;
    logic       ncli;
    logic       nljr;
    logic       cyc;
    logic       req;
    logic       fet;
    logic       stl;
    logic       ack;
    logic       ie;
    logic       be;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];

  control_seq #(
    .INST_W (8),
    .WAIT_W (4),
    .TIMEOUT(15)
  ) dut (
    .clk    (clk),
    .nRST   (nRST),
    .inst   (inst),
    .mem_rdy(mem_rdy),
    .irq    (irq),
    .nCLI   (nCLI),
    .nLJR   (nLJR),
    .cycle  (cycle),
    .mem_req(mem_req),
    .fetch  (fetch),
    .stall  (stall),
    .irq_ack(irq_ack),
    .ie     (ie),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic rst, logic [7:0] in, logic rdy, logic rq,
                              logic ncli, logic nljr, logic cyc, logic req, logic fet,
                              logic stl, logic ack, logic ien, logic be);
    vec_t v;
    v.name = nm; v.rst = rst; v.inst = in; v.rdy = rdy; v.irq = rq;
    v.ncli = ncli; v.nljr = nljr; v.cyc = cyc; v.req = req; v.fet = fet;
    v.stl = stl; v.ack = ack; v.ie = ien; v.be = be;
    return v;
  endfunction

  task automatic chk(string nm, string sig, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %b expected %b at %0t", nm, sig, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v);
    @(posedge clk);
    #1;
    nRST    = v.rst;
    inst    = v.inst;
    mem_rdy = v.rdy;
    irq     = v.irq;
    nCLI    = v.ncli;
    nLJR    = v.nljr;
    expQ.push_back(v);
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      vec_t e;
      e = expQ.pop_front();
      chk(e.name, "cycle",   cycle,   e.cyc);
      chk(e.name, "mem_req", mem_req, e.req);
      chk(e.name, "fetch",   fetch,   e.fet);
      chk(e.name, "stall",   stall,   e.stl);
      chk(e.name, "irq_ack", irq_ack, e.ack);
      chk(e.name, "ie",      ie,      e.ie);
      chk(e.name, "bus_err", bus_err, e.be);
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    nRST    = 1'b0;
    inst    = 8'h05;
    mem_rdy = 1'b1;
    irq     = 1'b0;
    nCLI    = 1'b1;
    nLJR    = 1'b1;

    //              name         rst inst  rdy irq cli ljr  cyc req fet stl ack ie        be
    vecs.push_back(mk("rst",      0, 8'h05, 1, 0, 1, 1,   0,  0,  0,  0,  0,  0,        0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("one_ph", 1, 8'h05, 1, 0, 1, 1,   0,  0,  1,  0,  0,  0,        0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("mem_st0", 1, 8'h80, 0, 0, 1, 1,  0,  1,  0,  1,  0,  0,        0));
    vecs.push_back(mk("mem_rdy0", 1, 8'h80, 1, 0, 1, 1,   0,  1,  0,  0,  0,  0,        0));
    vecs.push_back(mk("mem_ret",  1, 8'h80, 1, 0, 1, 1,   1,  1,  1,  0,  0,  0,        0));
    vecs.push_back(mk("jmp_st0",  1, 8'hE0, 0, 0, 1, 1,   0,  1,  0,  1,  0,  0,        0));
    vecs.push_back(mk("jmp_rdy0", 1, 8'hE0, 1, 0, 1, 1,   0,  1,  0,  0,  0,  0,        0));
    vecs.push_back(mk("jmp_ret",  1, 8'hE0, 0, 0, 1, 1,   1,  0,  1,  0,  0,  0,        0));
    vecs.push_back(mk("m1_rdy0",  1, 8'h80, 1, 0, 1, 1,   0,  1,  0,  0,  0,  0,        0));
    vecs.push_back(mk("m1_st1",   1, 8'h80, 0, 0, 1, 1,   1,  1,  0,  1,  0,  0,        0));
    vecs.push_back(mk("m1_ret",   1, 8'h80, 1, 0, 1, 1,   1,  1,  1,  0,  0,  0,        0));
    // Reset while stalled
    vecs.push_back(mk("rs_st",    1, 8'h80, 0, 0, 1, 1,   0,  1,  0,  1,  0,  0,        0));
    vecs.push_back(mk("rs_rst",   0, 8'h80, 0, 0, 1, 1,   0,  0,  0,  0,  0,  0,        0));
    vecs.push_back(mk("rs_after", 1, 8'h05, 1, 0, 1, 1,   0,  0,  1,  0,  0,  0,        0));
    // Counter clears on mem_rdy and state change: two 10-clock stalls never time out
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk("clr_st0", 1, 8'h80, 0, 0, 1, 1,  0,  1,  0,  1,  0,  0,        0));
    vecs.push_back(mk("clr_rdy0", 1, 8'h80, 1, 0, 1, 1,   0,  1,  0,  0,  0,  0,        0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk("clr_st1", 1, 8'h80, 0, 0, 1, 1,  1,  1,  0,  1,  0,  0,        0));
    vecs.push_back(mk("clr_ret",  1, 8'h80, 1, 0, 1, 1,   1,  1,  1,  0,  0,  0,        0));
    // Timeout: 16 stalled clocks, then sticky ERR until reset
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk("to_st",   1, 8'h80, 0, 0, 1, 1,  0,  1,  0,  1,  0,  0,        0));
    vecs.push_back(mk("to_err",   1, 8'h80, 0, 0, 1, 1,   0,  0,  0,  0,  0,  0,        1));
    vecs.push_back(mk("err_rdy",  1, 8'h80, 1, 0, 1, 1,   0,  0,  0,  0,  0,  0,        1));
    vecs.push_back(mk("err_one",  1, 8'h05, 1, 1, 1, 0,   0,  0,  0,  0,  0,  0,        1));
    vecs.push_back(mk("err_rst",  0, 8'h05, 1, 0, 1, 1,   0,  0,  0,  0,  0,  0,        1));
    vecs.push_back(mk("err_clr",  1, 8'h05, 1, 0, 1, 1,   0,  0,  1,  0,  0,  0,        0));
    // Interrupt entry: set ie, take irq at next retire
    vecs.push_back(mk("ljr_set",  1, 8'h05, 1, 0, 1, 0,   0,  0,  1,  0,  0,  0,        0));
    vecs.push_back(mk("irq_ret",  1, 8'h05, 1, 1, 1, 1,   0,  0,  1,  0,  0,  IrqEn,    0));
    vecs.push_back(mk("irq_ack",  1, 8'h05, 1, 0, 1, 1,   0,  0, !IrqEn, 0, IrqEn, IrqEn, 0));
    vecs.push_back(mk("irq_post", 1, 8'h05, 1, 0, 1, 1,   0,  0,  1,  0,  0,  0,        0));
    // Clear wins over set: no ack despite irq
    vecs.push_back(mk("ljr_set2", 1, 8'h05, 1, 0, 1, 0,   0,  0,  1,  0,  0,  0,        0));
    vecs.push_back(mk("cli_ljr",  1, 8'h05, 1, 1, 0, 0,   0,  0,  1,  0,  0,  IrqEn,    0));
    vecs.push_back(mk("no_ack",   1, 8'h05, 1, 1, 1, 1,   0,  0,  1,  0,  0,  0,        0));
    vecs.push_back(mk("no_ack2",  1, 8'h05, 1, 0, 1, 1,   0,  0,  1,  0,  0,  0,        0));
    // irq outside a retire clock is not latched
    vecs.push_back(mk("ljr_set3", 1, 8'h05, 1, 0, 1, 0,   0,  0,  1,  0,  0,  0,        0));
    vecs.push_back(mk("nl_ex0",   1, 8'h80, 1, 1, 1, 1,   0,  1,  0,  0,  0,  IrqEn,    0));
    vecs.push_back(mk("nl_ret",   1, 8'h80, 1, 0, 1, 1,   1,  1,  1,  0,  0,  IrqEn,    0));
    vecs.push_back(mk("nl_none",  1, 8'h05, 1, 0, 0, 1,   0,  0,  1,  0,  0,  IrqEn,    0));
    vecs.push_back(mk("cli_done", 1, 8'h05, 1, 0, 1, 1,   0,  0,  1,  0,  0,  0,        0));

    // First edge with reset low brings the DUT to a known state unchecked.
    @(posedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
